// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch / load-store memory port arbiter.
//   addr_t, data_t   : 32-bit address and data buses
//   byte_en_t        : 4-bit byte enables
//   arb_state_t      : arbiter FSM states (IDLE, ISSUE, RESP)
//   port_id_t        : requesting port identifier (PORT_IF, PORT_LS)
package mem_port_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_t;

  localparam byte_en_t BE_FULL = 4'hF;

  // Memory is word-addressed; low two byte-address bits are dropped.
  function automatic addr_t word_align(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

  // Timeout counter width: enough to hold TIMEOUT_CYCLES, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way grant for the memory port arbiter.
//   req_if, req_ls : request valids from fetch and load/store ports
//   last_owner     : port that owned the previous transaction
//   gnt_if, gnt_ls : one-hot grant (both low when nobody requests)
// PRIORITY_MODE=0 alternates on contention, PRIORITY_MODE=1 always favours LS.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic     req_if,
  input  logic     req_ls,
  input  port_id_t last_owner,
  output logic     gnt_if,
  output logic     gnt_ls
);

  always_comb begin
    gnt_ls = req_ls && (!req_if || (PRIORITY_MODE != 0) || (last_owner == PORT_IF));
    gnt_if = req_if && !gnt_ls;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch unit (read-only) and the
// load/store path. One transaction at a time: accept in IDLE, hold mem_req in
// ISSUE until mem_ack (or timeout), pulse the owner's response in RESP.
//   clk, reset            : clock, asynchronous active-low reset
//   if_req_* / if_rsp_*   : fetch request handshake and response
//   ls_req_* / ls_rsp_*   : load/store request handshake and response
//   mem_*                 : memory request (held until mem_ack) and read data
//   busy                  : arbiter not idle
//   owner                 : port of the current or most recent transaction
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned LAST_CNT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  port_id_t         owner_q,        owner_d;
  port_id_t         last_owner_q,   last_owner_d;
  logic             we_q,           we_d;
  byte_en_t         be_q,           be_d;
  addr_t            addr_q,         addr_d;
  data_t            wdata_q,        wdata_d;
  logic             mem_req_q,      mem_req_d;
  logic             if_rsp_valid_q, if_rsp_valid_d;
  logic             ls_rsp_valid_q, ls_rsp_valid_d;
  data_t            if_rdata_q,     if_rdata_d;
  data_t            ls_rdata_q,     ls_rdata_d;
  logic             if_err_q,       if_err_d;
  logic             ls_err_q,       ls_err_d;

  logic  gnt_if, gnt_ls;
  logic  idle;
  logic  timeout_hit;
  logic  finish;
  data_t rsp_data;
  logic  rsp_err;

  rr_arbiter2 #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_arb (
    .req_if     (if_req_valid),
    .req_ls     (ls_req_valid),
    .last_owner (last_owner_q),
    .gnt_if     (gnt_if),
    .gnt_ls     (gnt_ls)
  );

  assign idle         = (state_q == IDLE);
  assign if_req_ready = idle && gnt_if;
  assign ls_req_ready = idle && gnt_ls;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    we_d           = we_q;
    be_d           = be_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_req_d      = mem_req_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    if_rdata_d     = if_rdata_q;
    ls_rdata_d     = ls_rdata_q;
    if_err_d       = if_err_q;
    ls_err_d       = ls_err_q;
    finish         = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_if || gnt_ls) begin
          owner_d      = gnt_ls ? PORT_LS : PORT_IF;
          last_owner_d = gnt_ls ? PORT_LS : PORT_IF;
          we_d         = gnt_ls ? ls_we : 1'b0;
          be_d         = gnt_ls ? ls_be : BE_FULL;
          addr_d       = word_align(gnt_ls ? ls_addr : if_addr);
          wdata_d      = gnt_ls ? ls_wdata : '0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          // An ack landing on the timeout cycle still completes normally.
          finish   = 1'b1;
          rsp_data = we_q ? '0 : mem_rdata;
          rsp_err  = 1'b0;
        end else begin
          if (timeout_hit) begin
            finish   = 1'b1;
            rsp_data = '0;
            rsp_err  = 1'b1;
          end
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (finish) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == PORT_LS) begin
            ls_rsp_valid_d = 1'b1;
            ls_rdata_d     = rsp_data;
            ls_err_d       = rsp_err;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rdata_d     = rsp_data;
            if_err_d       = rsp_err;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      owner_q        <= PORT_IF;
      last_owner_q   <= PORT_LS;
      we_q           <= 1'b0;
      be_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      mem_req_q      <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rdata_q     <= '0;
      ls_rdata_q     <= '0;
      if_err_q       <= 1'b0;
      ls_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      we_q           <= we_d;
      be_q           <= be_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mem_req_q      <= mem_req_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rdata_q     <= if_rdata_d;
      ls_rdata_q     <= ls_rdata_d;
      if_err_q       <= if_err_d;
      ls_err_q       <= ls_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;
  assign if_err       = if_err_q;
  assign ls_err       = ls_err_q;
  assign busy         = !idle;
  assign owner        = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin with 4-cycle timeout,
// fixed priority with timeout disabled) share request stimulus; each has its
// own memory responder. A transaction-level model predicts every output on
// every cycle from accept time A and memory delay d:
//   mem_req in A+1..E, E = A+min(d,TIMEOUT) (or A+d when disabled),
//   response pulse in E+1, idle again from E+2.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv, lv, lwe;
  logic [3:0]  lbe;
  logic [31:0] ia, la, lwd;

  logic        if_rdy [2], if_rv [2], if_er [2];
  logic        ls_rdy [2], ls_rv [2], ls_er [2];
  logic        mreq [2], mwe [2], mack [2], busy [2], own_o [2];
  logic [31:0] if_rd [2], ls_rd [2], maddr [2], mwd [2], mrd [2];
  logic [3:0]  mbe [2];

  mem_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset),
    .if_req_valid(iv), .if_req_ready(if_rdy[0]), .if_addr(ia),
    .if_rsp_valid(if_rv[0]), .if_rdata(if_rd[0]), .if_err(if_er[0]),
    .ls_req_valid(lv), .ls_req_ready(ls_rdy[0]), .ls_we(lwe), .ls_be(lbe),
    .ls_addr(la), .ls_wdata(lwd),
    .ls_rsp_valid(ls_rv[0]), .ls_rdata(ls_rd[0]), .ls_err(ls_er[0]),
    .mem_req(mreq[0]), .mem_we(mwe[0]), .mem_be(mbe[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwd[0]), .mem_ack(mack[0]), .mem_rdata(mrd[0]),
    .busy(busy[0]), .owner(own_o[0]));

  mem_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .if_req_valid(iv), .if_req_ready(if_rdy[1]), .if_addr(ia),
    .if_rsp_valid(if_rv[1]), .if_rdata(if_rd[1]), .if_err(if_er[1]),
    .ls_req_valid(lv), .ls_req_ready(ls_rdy[1]), .ls_we(lwe), .ls_be(lbe),
    .ls_addr(la), .ls_wdata(lwd),
    .ls_rsp_valid(ls_rv[1]), .ls_rdata(ls_rd[1]), .ls_err(ls_er[1]),
    .mem_req(mreq[1]), .mem_we(mwe[1]), .mem_be(mbe[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwd[1]), .mem_ack(mack[1]), .mem_rdata(mrd[1]),
    .busy(busy[1]), .owner(own_o[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // staged request inputs, applied just after the next rising edge
  logic        s_iv, s_lv, s_lwe;
  logic [3:0]  s_lbe;
  logic [31:0] s_ia, s_la, s_lwd;

  int          force_d = 0;
  bit          force_data_en = 0;
  logic [31:0] force_data = '0;
  bit          stray = 0;
  bit          stray_all = 0;

  int          pm   [2] = '{0, 1};
  int          to_c [2] = '{4, 0};

  // model state per instance
  bit          infl [2];
  int          acc [2], ecyc [2], tdel [2];
  bit          own [2], lastown [2], twe [2], terr [2];
  logic [3:0]  tbe [2];
  logic [31:0] taddr [2], twd [2], tdata [2];
  logic [31:0] exp_rd [2][2];
  bit          exp_er [2][2];

  // observations for the directed literal checks
  int          reqcnt [2], ifacc [2], lsacc [2], gcnt [2], rspcnt [2];
  logic [3:0]  gseq [2];
  logic [31:0] last_rd [2];
  logic        last_er [2];

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=0x%08h required=0x%08h", name, k, cyc, act, expv);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      infl[k] = 0; own[k] = 0; lastown[k] = 1;
      for (int p = 0; p < 2; p++) begin
        exp_rd[k][p] = '0; exp_er[k][p] = 0;
      end
    end
  endfunction

  function automatic void clear_obs();
    for (int k = 0; k < 2; k++) begin
      reqcnt[k] = 0; ifacc[k] = 0; lsacc[k] = 0; gcnt[k] = 0; rspcnt[k] = 0;
      gseq[k] = '0; last_rd[k] = '0; last_er[k] = 1'b0;
    end
  endfunction

  function automatic int rand_delay(int k);
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 9) return r + 1;
    return (k == 1) ? 70 : 12;
  endfunction

  task automatic run_cycle();
    bit win, rsp, gls, gif;
    @(posedge clk);
    #1;
    cyc++;
    iv = s_iv; lv = s_lv; lwe = s_lwe; lbe = s_lbe; ia = s_ia; la = s_la; lwd = s_lwd;
    for (int k = 0; k < 2; k++) begin
      if (infl[k] && cyc >= acc[k] + 1 && cyc <= ecyc[k]) begin
        mack[k] = (cyc == acc[k] + tdel[k]);
        mrd[k]  = mack[k] ? tdata[k] : $urandom;
      end else begin
        mack[k] = stray_all || (stray && ($urandom_range(0, 2) == 0));
        mrd[k]  = $urandom;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (infl[k] && cyc >= ecyc[k] + 2) infl[k] = 0;
      if (infl[k] && cyc == ecyc[k] + 1) begin
        exp_rd[k][own[k]] = (terr[k] || twe[k]) ? 32'h0 : tdata[k];
        exp_er[k][own[k]] = terr[k];
      end
      win = infl[k] && cyc >= acc[k] + 1 && cyc <= ecyc[k];
      rsp = infl[k] && cyc == ecyc[k] + 1;
      gls = !infl[k] && lv && (!iv || pm[k] != 0 || lastown[k] == 0);
      gif = !infl[k] && iv && !gls;

      chk("if_ready", k, if_rdy[k], gif);
      chk("ls_ready", k, ls_rdy[k], gls);
      chk("busy", k, busy[k], infl[k]);
      chk("mem_req", k, mreq[k], win);
      chk("owner", k, own_o[k], own[k]);
      chk("if_rsp_valid", k, if_rv[k], rsp && !own[k]);
      chk("ls_rsp_valid", k, ls_rv[k], rsp && own[k]);
      chk("if_rdata", k, if_rd[k], exp_rd[k][0]);
      chk("if_err", k, if_er[k], exp_er[k][0]);
      chk("ls_rdata", k, ls_rd[k], exp_rd[k][1]);
      chk("ls_err", k, ls_er[k], exp_er[k][1]);
      if (win) begin
        chk("mem_addr", k, maddr[k], {taddr[k][31:2], 2'b00});
        chk("mem_we", k, mwe[k], twe[k]);
        chk("mem_be", k, mbe[k], tbe[k]);
        if (twe[k]) chk("mem_wdata", k, mwd[k], twd[k]);
      end

      if (mreq[k]) reqcnt[k]++;
      if (if_rdy[k]) ifacc[k]++;
      if (ls_rdy[k]) lsacc[k]++;
      if ((if_rdy[k] || ls_rdy[k]) && gcnt[k] < 4) begin
        gseq[k] = {gseq[k][2:0], ls_rdy[k]};
        gcnt[k]++;
      end
      if (if_rv[k] || ls_rv[k]) begin
        rspcnt[k]++;
        last_rd[k] = ls_rv[k] ? ls_rd[k] : if_rd[k];
        last_er[k] = ls_rv[k] ? ls_er[k] : if_er[k];
      end

      if (gif || gls) begin
        infl[k]    = 1;
        acc[k]     = cyc;
        own[k]     = gls;
        lastown[k] = gls;
        twe[k]     = gls ? lwe : 1'b0;
        tbe[k]     = gls ? lbe : 4'hF;
        taddr[k]   = gls ? la : ia;
        twd[k]     = lwd;
        tdel[k]    = (force_d > 0) ? force_d : rand_delay(k);
        tdata[k]   = force_data_en ? force_data : $urandom;
        terr[k]    = (to_c[k] != 0) && (tdel[k] > to_c[k]);
        ecyc[k]    = terr[k] ? acc[k] + to_c[k] : acc[k] + tdel[k];
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    s_iv = 0; s_lv = 0;
    while ((infl[0] || infl[1]) && n < 300) begin
      run_cycle();
      n++;
    end
    chk("idle_bound", 0, {31'b0, infl[0] || infl[1]}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    s_iv = 0; s_lv = 0; s_lwe = 0; s_lbe = '0; s_ia = '0; s_la = '0; s_lwd = '0;
    iv = 0; lv = 0; lwe = 0; lbe = '0; ia = '0; la = '0; lwd = '0;
    for (int k = 0; k < 2; k++) begin mack[k] = 1'b0; mrd[k] = '0; end
    model_reset();
    clear_obs();

    // reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_req", k, mreq[k], 0);
      chk("rst_busy", k, busy[k], 0);
      chk("rst_owner", k, own_o[k], 0);
      chk("rst_if_rsp", k, if_rv[k], 0);
      chk("rst_ls_rsp", k, ls_rv[k], 0);
      chk("rst_if_rdata", k, if_rd[k], 0);
      chk("rst_ls_rdata", k, ls_rd[k], 0);
      chk("rst_mem_addr", k, maddr[k], 0);
      chk("rst_ready", k, {if_rdy[k], ls_rdy[k]}, 0);
    end
    reset = 1'b1;

    // round-robin vs fixed priority, both valids held from reset
    force_d = 2; s_iv = 1; s_lv = 1; s_lwe = 0; s_ia = 32'h100; s_la = 32'h200;
    for (int n = 0; n < 100 && (gcnt[0] < 4 || gcnt[1] < 4); n++) run_cycle();
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("rr_count", k, gcnt[k], 4);
      chk("rr_order", k, {28'b0, gseq[k]}, (k == 0) ? 32'h5 : 32'hF);
    end

    // fetch only
    clear_obs(); force_d = 3; force_data_en = 1; force_data = 32'h0000_0013;
    s_iv = 1; s_ia = 32'h0000_0104; s_lv = 0;
    run_cycle();
    s_iv = 0;
    for (int j = 1; j <= 4; j++) begin
      run_cycle();
      for (int k = 0; k < 2; k++) begin
        if (j == 1) begin
          chk("fetch_mem_addr", k, maddr[k], 32'h0000_0104);
          chk("fetch_mem_we", k, mwe[k], 0);
          chk("fetch_mem_be", k, mbe[k], 32'hF);
        end
        if (j == 4) begin
          chk("fetch_rsp", k, if_rv[k], 1);
          chk("fetch_rdata", k, if_rd[k], 32'h0000_0013);
          chk("fetch_err", k, if_er[k], 0);
          chk("fetch_ls_rsp", k, ls_rv[k], 0);
        end
      end
    end
    wait_idle();

    // store
    force_d = 2; force_data = 32'hFFFF_FFFF;
    s_lv = 1; s_lwe = 1; s_lbe = 4'b0011; s_la = 32'h0000_2006; s_lwd = 32'hDEAD_BEEF;
    run_cycle();
    s_lv = 0;
    for (int j = 1; j <= 3; j++) begin
      run_cycle();
      for (int k = 0; k < 2; k++) begin
        if (j == 1) begin
          chk("store_mem_addr", k, maddr[k], 32'h0000_2004);
          chk("store_mem_be", k, mbe[k], 32'h3);
          chk("store_mem_wdata", k, mwd[k], 32'hDEAD_BEEF);
          chk("store_mem_we", k, mwe[k], 1);
        end
        if (j == 3) begin
          chk("store_rsp", k, ls_rv[k], 1);
          chk("store_rdata", k, ls_rd[k], 0);
        end
      end
    end
    wait_idle();

    // hung memory: dut0 times out after 4 cycles, dut1 waits it out
    clear_obs(); force_d = 100; force_data = 32'hCAFE_0001;
    s_lv = 1; s_lwe = 0; s_la = 32'h0000_0040;
    run_cycle();
    wait_idle();
    chk("to_req_cycles", 0, reqcnt[0], 4);
    chk("to_err", 0, last_er[0], 1);
    chk("to_rdata", 0, last_rd[0], 0);
    chk("noto_req_cycles", 1, reqcnt[1], 100);
    chk("noto_err", 1, last_er[1], 0);
    chk("noto_rdata", 1, last_rd[1], 32'hCAFE_0001);

    // ack on the 4th ISSUE cycle beats the timeout
    clear_obs(); force_d = 4; force_data = 32'h1234_5678;
    s_lv = 1;
    run_cycle();
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("ack4_req_cycles", k, reqcnt[k], 4);
      chk("ack4_err", k, last_er[k], 0);
      chk("ack4_rdata", k, last_rd[k], 32'h1234_5678);
    end

    // fetch valid withdrawn before it could be accepted
    clear_obs(); force_d = 2; force_data_en = 0;
    s_iv = 0; s_lv = 1; s_lwe = 0;
    run_cycle();
    s_iv = 1;
    for (int j = 0; j < 3; j++) run_cycle();
    s_iv = 0;
    run_cycle();
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("withdraw_if_acc", k, ifacc[k], 0);
      chk("withdraw_ls_acc", k, lsacc[k], 2);
    end

    // randomized traffic with stray acks outside ISSUE
    force_d = 0; stray = 1;
    for (int n = 0; n < 400; n++) begin
      s_iv  = 1'($urandom_range(0, 1));
      s_lv  = 1'($urandom_range(0, 1));
      s_lwe = 1'($urandom_range(0, 1));
      s_lbe = 4'($urandom);
      s_ia  = $urandom;
      s_la  = $urandom;
      s_lwd = $urandom;
      run_cycle();
    end
    stray = 0;
    wait_idle();

    // asynchronous reset during ISSUE, then stale acks
    force_d = 50; s_lv = 1; s_lwe = 0; s_la = 32'h0000_0080;
    run_cycle();
    s_lv = 0;
    run_cycle();
    run_cycle();
    chk("pre_reset_req", 0, mreq[0], 1);
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_mem_req", k, mreq[k], 0);
      chk("arst_busy", k, busy[k], 0);
      chk("arst_owner", k, own_o[k], 0);
      chk("arst_ls_rdata", k, ls_rd[k], 0);
    end
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    clear_obs(); stray_all = 1;
    for (int j = 0; j < 4; j++) run_cycle();
    stray_all = 0;
    for (int k = 0; k < 2; k++) chk("stale_ack_rsp", k, rspcnt[k], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the fetch unit (read-only) and the load/store path (read/write) of the multicycle core.
- Sits between fetch/ControlFSM and the unified memory.
- Arbitrates simultaneous requests, serialises one transaction at a time and routes each response back to its owner.
- Times out hung memory accesses with an error response.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, LS port always wins.
- TIMEOUT_CYCLES, 64, cycles in ISSUE without mem_ack before error response; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request pending
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_rsp_valid  out  1  one-cycle pulse, fetch response available
- if_rdata  out  32  fetch read data
- if_err  out  1  qualifies if_rsp_valid, timeout occurred
- ls_req_valid  in  1  load/store request pending
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  byte enables for store
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data
- ls_rsp_valid  out  1  one-cycle pulse, load/store response
- ls_rdata  out  32  load data (0 for stores)
- ls_err  out  1  qualifies ls_rsp_valid, timeout occurred
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = LS; owner of current or last transaction

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset (reset==0, asynchronous) forces:
  - state IDLE, counter 0, last_owner=1 (LS);
  - all outputs 0, including mem_req, rsp_valid/err and rdata registers.
- IDLE:
  - Only state in which ready may be high. ready is combinational from state and both valids.
  - Exactly one ready is high when any valid is high.
  - Winner on a simultaneous request:
    - PRIORITY_MODE=1: LS.
    - PRIORITY_MODE=0: the port that is not last_owner.
  - Single requester always wins.
  - Handshake fires when valid&&ready. At that edge:
    - capture addr/we/be/wdata; fetch requests use we=0, be=4'hF;
    - set owner and last_owner;
    - clear the counter; go to ISSUE.
- ISSUE:
  - mem_req=1; mem_* driven from the captured registers and held stable until mem_ack.
  - Counter increments each cycle without mem_ack.
  - mem_ack=1: capture mem_rdata (0 for stores), err=0, go to RESP.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: rdata=0, err=1, go to RESP.
  - mem_ack in the same cycle as timeout: ack wins, err=0.
- RESP:
  - Owner's rsp_valid=1 for exactly one cycle; the other port's rsp_valid=0; mem_req=0.
  - rdata/err remain stable until the next response.
  - Next state IDLE.
- No response back-pressure: requesters must consume rsp_valid in that cycle.
- Latency:
  - Accept at edge T; mem_req high in cycle T+1.
  - mem_ack in cycle T+k gives rsp_valid in cycle T+k+1.
  - Minimum spacing between accepts is 3 cycles.
- mem_ack while in IDLE or RESP: ignored; includes stale acks after a reset mid-transaction.
- A requester dropping valid before ready: no transaction, no state change.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.

Decomposition:
- types.svh additions:
  - addr_t (32-bit);
  - byte_en_t (4-bit);
  - arb_state_t enum {IDLE, ISSUE, RESP};
  - port_id_t (PORT_IF=0, PORT_LS=1).
- data_t is reused for data buses.
- One sub-module, rr_arbiter2: a combinational 2-way grant from two valids, last_owner and PRIORITY_MODE. The FSM, capture registers and timeout counter stay in the top module.

Test Plan:
- Fetch only: if_addr=0x0000_0104, mem_ack 2 cycles after mem_req with rdata=0x0000_0013.
  - Expect mem_addr=0x0000_0104, mem_we=0, mem_be=4'hF.
  - Expect if_rsp_valid one cycle later with if_rdata=0x0000_0013, if_err=0, ls_rsp_valid=0.
- Store: ls_we=1, ls_be=4'b0011, ls_addr=0x0000_2006, ls_wdata=0xDEAD_BEEF.
  - Expect mem_addr=0x0000_2004, mem_be=4'b0011, mem_wdata=0xDEAD_BEEF.
  - Expect ls_rsp_valid with ls_rdata=0.
- Round-robin (PRIORITY_MODE=0): both valids held high from reset for 4 transactions.
  - Grant order IF, LS, IF, LS.
  - PRIORITY_MODE=1: LS, LS, LS, LS.
- Timeout, TIMEOUT_CYCLES=4, mem_ack never asserted:
  - mem_req high exactly 4 cycles, then ls_rsp_valid with ls_err=1, ls_rdata=0.
  - mem_ack arriving on the 4th cycle gives err=0 and mem_rdata returned.
- Reset mid-ISSUE: assert reset low asynchronously.
  - mem_req drops immediately; busy=0.
  - An mem_ack after reset release produces no rsp_valid.
- Mid-handshake withdrawal: if_req_valid pulses low before accept, while ls_req_valid stays high.
  - LS wins; no fetch transaction occurs.
